// File: rtl/morse_capture_ctrl_pkg.sv
// Shared widths, FSM encodings, symbol record layout and the threshold
// saturation helper for the Morse capture controller.
package morse_capture_ctrl_pkg;

  localparam int PULSE_CNT_W   = 8;
  localparam int MORSE_LEN_W   = 3;
  localparam int MAX_MORSE_LEN = 6;
  localparam int SYM_REC_W     = MORSE_LEN_W + MAX_MORSE_LEN + 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LOW = 2'd1,
    ST_START    = 2'd2,
    ST_RUN      = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [MORSE_LEN_W-1:0]   len;
    logic [MAX_MORSE_LEN-1:0] dits_dahs;
    logic                     error;
    logic                     has_char;
    logic                     space;
  } sym_rec_t;

  // Products are formed three bits wider than a threshold (7*dit fits there).
  function automatic logic [PULSE_CNT_W-1:0] sat_fit(input logic [PULSE_CNT_W+2:0] value);
    if (|value[PULSE_CNT_W+2:PULSE_CNT_W]) begin
      return '1;
    end
    return value[PULSE_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/morse_capture_ctrl_if.sv
// Symbol record handshake between the capture controller and the decoder.
interface morse_capture_ctrl_if;
  import morse_capture_ctrl_pkg::*;

  logic                     valid;
  logic                     ready;
  logic [MORSE_LEN_W-1:0]   len;
  logic [MAX_MORSE_LEN-1:0] dits_dahs;
  logic                     error;
  logic                     has_char;
  logic                     space;

  modport master (
    output valid, len, dits_dahs, error, has_char, space,
    input  ready
  );

  modport slave (
    input  valid, len, dits_dahs, error, has_char, space,
    output ready
  );

endinterface

// File: rtl/morse_capture_ctrl_sym_fifo.sv
// Small synchronous FIFO for symbol records; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module morse_sym_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_last;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Remember the last popped record so the outputs hold while empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= '0;
    end else if (w_do_pop) begin
      r_last <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign o_data = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/morse_capture_ctrl.sv
// Capture sequencer: derives timing thresholds from the dit time, pulses
// capture start, and queues character / word-gap records for the decoder.
module morse_capture_ctrl
  import morse_capture_ctrl_pkg::*;
#(
  parameter int DEFAULT_DIT = 10,
  parameter int TOL_SHIFT   = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ce,
  input  logic                     i_enable,
  input  logic                     i_signal,
  input  logic                     i_cfg_we,
  input  logic [PULSE_CNT_W-1:0]   i_cfg_dit,
  output logic [PULSE_CNT_W-1:0]   o_dit_time,
  output logic [PULSE_CNT_W-1:0]   o_dah_time,
  output logic [PULSE_CNT_W-1:0]   o_word_time,
  output logic [PULSE_CNT_W-1:0]   o_tol_time,
  output logic                     o_cap_start,
  input  logic [MORSE_LEN_W-1:0]   i_cap_len,
  input  logic [MAX_MORSE_LEN-1:0] i_cap_dits_dahs,
  input  logic                     i_cap_error,
  input  logic                     i_cap_word_end,
  input  logic                     i_cap_ceo,
  morse_capture_ctrl_if.master     sym_if,
  output logic                     o_overflow,
  output logic                     o_busy
);

  localparam logic [PULSE_CNT_W-1:0] DIT_RST = DEFAULT_DIT[PULSE_CNT_W-1:0];

  ctrl_state_t            r_state;
  ctrl_state_t            w_state_nxt;
  logic [PULSE_CNT_W-1:0] r_dit;
  logic                   r_cap_start;
  logic                   r_sig_d;
  logic                   r_char_pushed;
  logic                   r_overflow;
  logic [PULSE_CNT_W+2:0] w_dit_x;
  logic [PULSE_CNT_W+2:0] w_dah_raw;
  logic [PULSE_CNT_W+2:0] w_word_raw;
  logic                   w_cfg_accept;
  logic                   w_to_idle;
  logic                   w_char_evt;
  logic                   w_word_evt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  sym_rec_t               w_rec;
  sym_rec_t               w_head;
  logic [SYM_REC_W-1:0]   w_head_bits;

  assign w_cfg_accept = i_cfg_we && (r_state == ST_IDLE);
  assign w_to_idle    = i_ce && !i_enable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dit <= DIT_RST;
    end else if (w_cfg_accept) begin
      r_dit <= (i_cfg_dit == '0) ? PULSE_CNT_W'(1) : i_cfg_dit;
    end
  end

  assign w_dit_x    = {3'b000, r_dit};
  assign w_dah_raw  = (w_dit_x << 1) + w_dit_x;
  assign w_word_raw = (w_dit_x << 2) + (w_dit_x << 1) + w_dit_x;

  assign o_dit_time  = r_dit;
  assign o_dah_time  = sat_fit(w_dah_raw);
  assign o_word_time = sat_fit(w_word_raw);
  assign o_tol_time  = r_dit >> TOL_SHIFT;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (i_enable) w_state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!i_signal) w_state_nxt = ST_START;
      ST_START:    w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_cap_ceo && i_cap_word_end) begin
          w_state_nxt = i_cap_error ? ST_WAIT_LOW : ST_START;
        end
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (!i_enable) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cap_start <= 1'b0;
      r_sig_d     <= 1'b0;
    end else if (i_ce) begin
      r_state     <= w_state_nxt;
      r_cap_start <= (w_state_nxt == ST_START);
      r_sig_d     <= i_signal;
    end
  end

  assign o_cap_start = r_cap_start;
  assign o_busy      = (r_state != ST_IDLE);

  assign w_char_evt = (r_state == ST_RUN) && i_cap_ceo && !i_cap_word_end;
  assign w_word_evt = (r_state == ST_RUN) && i_cap_ceo && i_cap_word_end;

  // A character reported since the last key-down means the word record
  // only marks the gap and carries no character of its own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_char_pushed <= 1'b0;
    end else if (i_ce) begin
      if (w_char_evt) begin
        r_char_pushed <= 1'b1;
      end else if ((i_signal && !r_sig_d) || (r_state == ST_START)) begin
        r_char_pushed <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rec           = '0;
    w_rec.len       = i_cap_len;
    w_rec.dits_dahs = i_cap_dits_dahs;
    w_rec.error     = i_cap_error;
    w_rec.has_char  = i_cap_word_end ? (!r_char_pushed && (i_cap_len != '0)) : 1'b1;
    w_rec.space     = i_cap_word_end && !i_cap_error;
  end

  assign w_push = i_ce && ((w_char_evt && (i_cap_len != '0)) || w_word_evt);
  assign w_pop  = sym_if.valid && sym_if.ready;

  morse_sym_fifo #(
    .WIDTH (SYM_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_sym_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_to_idle),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = sym_rec_t'(w_head_bits);

  assign sym_if.valid     = !w_empty;
  assign sym_if.len       = w_head.len;
  assign sym_if.dits_dahs = w_head.dits_dahs;
  assign sym_if.error     = w_head.error;
  assign sym_if.has_char  = w_head.has_char;
  assign sym_if.space     = w_head.space;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_cfg_accept || (r_state == ST_IDLE) || w_to_idle) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_morse_capture_ctrl.sv
// Directed bench for morse_capture_ctrl: timing derivation, start pulses,
// record packing, abort handling, FIFO full/overflow and async reset.
module tb_morse_capture_ctrl;
  import morse_capture_ctrl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ce;
  logic                     enable;
  logic                     signal;
  logic                     cfg_we;
  logic [PULSE_CNT_W-1:0]   cfg_dit;
  logic [PULSE_CNT_W-1:0]   dit_time;
  logic [PULSE_CNT_W-1:0]   dah_time;
  logic [PULSE_CNT_W-1:0]   word_time;
  logic [PULSE_CNT_W-1:0]   tol_time;
  logic                     cap_start;
  logic [MORSE_LEN_W-1:0]   cap_len;
  logic [MAX_MORSE_LEN-1:0] cap_dits_dahs;
  logic                     cap_error;
  logic                     cap_word_end;
  logic                     cap_ceo;
  logic                     overflow;
  logic                     busy;
  int                       compared   = 0;
  int                       mismatched = 0;
  int                       starts;

  morse_capture_ctrl_if sym_bus ();

  morse_capture_ctrl #(
    .DEFAULT_DIT (10),
    .TOL_SHIFT   (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ce            (ce),
    .i_enable        (enable),
    .i_signal        (signal),
    .i_cfg_we        (cfg_we),
    .i_cfg_dit       (cfg_dit),
    .o_dit_time      (dit_time),
    .o_dah_time      (dah_time),
    .o_word_time     (word_time),
    .o_tol_time      (tol_time),
    .o_cap_start     (cap_start),
    .i_cap_len       (cap_len),
    .i_cap_dits_dahs (cap_dits_dahs),
    .i_cap_error     (cap_error),
    .i_cap_word_end  (cap_word_end),
    .i_cap_ceo       (cap_ceo),
    .sym_if          (sym_bus),
    .o_overflow      (overflow),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wordEnd, input logic err,
                               input logic [MORSE_LEN_W-1:0] len,
                               input logic [MAX_MORSE_LEN-1:0] dd);
    cap_ceo       = 1'b1;
    cap_word_end  = wordEnd;
    cap_error     = err;
    cap_len       = len;
    cap_dits_dahs = dd;
    tick();
    cap_ceo      = 1'b0;
    cap_word_end = 1'b0;
    cap_error    = 1'b0;
  endtask

  task automatic setDit(input logic [PULSE_CNT_W-1:0] d);
    cfg_we  = 1'b1;
    cfg_dit = d;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic checkTiming(input string tag, input int d, input int dah, input int wrd, input int tol);
    checkOutput({tag, ".dit"},  32'(dit_time),  32'(d));
    checkOutput({tag, ".dah"},  32'(dah_time),  32'(dah));
    checkOutput({tag, ".word"}, 32'(word_time), 32'(wrd));
    checkOutput({tag, ".tol"},  32'(tol_time),  32'(tol));
  endtask

  task automatic popOne();
    sym_bus.ready = 1'b1;
    tick();
    sym_bus.ready = 1'b0;
  endtask

  function automatic logic [31:0] expRec(input logic valid, input logic [MORSE_LEN_W-1:0] len,
                                         input logic [MAX_MORSE_LEN-1:0] dd, input logic err,
                                         input logic hc, input logic sp);
    return 32'({valid, len, dd, err, hc, sp});
  endfunction

  function automatic logic [31:0] headRec();
    return 32'({sym_bus.valid, sym_bus.len, sym_bus.dits_dahs,
                sym_bus.error, sym_bus.has_char, sym_bus.space});
  endfunction

  initial begin
    rst_n         = 1'b0;
    ce            = 1'b1;
    enable        = 1'b0;
    signal        = 1'b1;
    cfg_we        = 1'b0;
    cfg_dit       = '0;
    cap_len       = '0;
    cap_dits_dahs = '0;
    cap_error     = 1'b0;
    cap_word_end  = 1'b0;
    cap_ceo       = 1'b0;
    sym_bus.ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkTiming("reset", 10, 30, 70, 2);
    checkOutput("reset.capStart", 32'(cap_start), 32'd0);
    checkOutput("reset.valid",    32'(sym_bus.valid), 32'd0);
    checkOutput("reset.overflow", 32'(overflow), 32'd0);
    checkOutput("reset.busy",     32'(busy), 32'd0);
    checkOutput("reset.record",   headRec(), 32'd0);
    rst_n = 1'b1;
    tick();

    setDit(8'd10);  checkTiming("cfg10", 10, 30, 70, 2);
    setDit(8'd0);   checkTiming("cfg0", 1, 3, 7, 0);
    setDit(8'd40);  checkTiming("cfg40", 40, 120, 255, 10);
    setDit(8'd100); checkTiming("cfg100", 100, 255, 255, 25);
    setDit(8'd8);   checkTiming("cfg8", 8, 24, 56, 2);

    enable = 1'b1;
    tick();
    checkOutput("enable.busy", 32'(busy), 32'd1);
    checkOutput("waitLow.capStart", 32'(cap_start), 32'd0);
    tick();
    checkOutput("waitLowHigh.capStart", 32'(cap_start), 32'd0);
    setDit(8'd20);
    checkOutput("cfgIgnored.dit", 32'(dit_time), 32'd8);

    signal = 1'b0;
    tick();
    checkOutput("start.capStart", 32'(cap_start), 32'd1);
    starts = int'(cap_start);
    for (int i = 0; i < 4; i++) begin
      tick();
      starts += int'(cap_start);
    end
    checkOutput("singleStart.count", 32'(starts), 32'd1);
    checkOutput("run.valid", 32'(sym_bus.valid), 32'd0);

    signal = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 3'd3, 6'b000010);
    checkOutput("charRec", headRec(), expRec(1'b1, 3'd3, 6'b000010, 1'b0, 1'b1, 1'b0));
    popOne();
    checkOutput("charHold", headRec(), expRec(1'b0, 3'd3, 6'b000010, 1'b0, 1'b1, 1'b0));

    applyStimulus(1'b1, 1'b0, 3'd0, 6'b000000);
    checkOutput("wordRec", headRec(), expRec(1'b1, 3'd0, 6'b000000, 1'b0, 1'b0, 1'b1));
    checkOutput("wordRestart.capStart", 32'(cap_start), 32'd1);
    popOne();
    checkOutput("wordStartDrop.capStart", 32'(cap_start), 32'd0);
    checkOutput("wordPopped.valid", 32'(sym_bus.valid), 32'd0);

    applyStimulus(1'b1, 1'b0, 3'd2, 6'b000011);
    checkOutput("lonelyWord", headRec(), expRec(1'b1, 3'd2, 6'b000011, 1'b0, 1'b1, 1'b1));
    popOne();

    applyStimulus(1'b1, 1'b1, 3'd1, 6'b000001);
    checkOutput("abortRec", headRec(), expRec(1'b1, 3'd1, 6'b000001, 1'b1, 1'b1, 1'b0));
    checkOutput("abortNoStart.capStart", 32'(cap_start), 32'd0);
    popOne();
    tick();
    tick();
    checkOutput("abortWait.capStart", 32'(cap_start), 32'd0);
    checkOutput("abortWait.busy", 32'(busy), 32'd1);
    ce = 1'b0;
    signal = 1'b0;
    tick();
    tick();
    checkOutput("ceHold.capStart", 32'(cap_start), 32'd0);
    ce = 1'b1;
    tick();
    checkOutput("abortRestart.capStart", 32'(cap_start), 32'd1);
    tick();

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, MORSE_LEN_W'(k), MAX_MORSE_LEN'(k));
    end
    checkOutput("fullNoOvf.overflow", 32'(overflow), 32'd0);
    checkOutput("fullHead", headRec(), expRec(1'b1, 3'd1, 6'd1, 1'b0, 1'b1, 1'b0));
    sym_bus.ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd5, 6'd5);
    sym_bus.ready = 1'b0;
    checkOutput("pushPopFull.overflow", 32'(overflow), 32'd0);
    checkOutput("pushPopFull.head", headRec(), expRec(1'b1, 3'd2, 6'd2, 1'b0, 1'b1, 1'b0));
    applyStimulus(1'b0, 1'b0, 3'd6, 6'd6);
    checkOutput("overflowSet", 32'(overflow), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      checkOutput("drainHead", headRec(),
                  expRec(1'b1, MORSE_LEN_W'(k), MAX_MORSE_LEN'(k), 1'b0, 1'b1, 1'b0));
      popOne();
    end
    checkOutput("drainEmpty", headRec(), expRec(1'b0, 3'd5, 6'd5, 1'b0, 1'b1, 1'b0));

    applyStimulus(1'b0, 1'b0, 3'd1, 6'd1);
    checkOutput("preFlush.valid", 32'(sym_bus.valid), 32'd1);
    enable = 1'b0;
    tick();
    checkOutput("flush.valid", 32'(sym_bus.valid), 32'd0);
    checkOutput("idle.busy", 32'(busy), 32'd0);
    checkOutput("idle.overflow", 32'(overflow), 32'd0);
    setDit(8'd20);
    checkTiming("cfg20", 20, 60, 140, 5);

    enable = 1'b1;
    signal = 1'b1;
    tick();
    signal = 1'b0;
    tick();
    checkOutput("preReset.capStart", 32'(cap_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset.capStart", 32'(cap_start), 32'd0);
    checkOutput("asyncReset.busy", 32'(busy), 32'd0);
    checkOutput("asyncReset.dit", 32'(dit_time), 32'd10);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/morse_capture_ctrl.md
# morse_capture_ctrl

Sequencer and configurator for the Morse character capture stage. Derives the four capture timing thresholds from one programmable unit (dit) time, and issues capture start pulses. It re-arms capture after every word end and after every abort. It packs each character and word-gap event into a symbol record and queues it in a small FIFO, which the downstream decoder drains with a valid/ready handshake.

## Interface
Parameters:
- `DEFAULT_DIT`, 10: dit_time after reset, in ce ticks.
- `TOL_SHIFT`, 2: tol_time = dit_time >> TOL_SHIFT.
- `FIFO_DEPTH`, 4: symbol FIFO entries; power of two, ≥2.

Ports (`PULSE_CNT_W`, `MORSE_LEN_W` and `MAX_MORSE_LEN` come from defines.vh):
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ce`  in  1: tick enable, the same one the capture stage uses.
- `enable`  in  1: receiver enable.
- `signal`  in  1: the keyed line, identical to the capture input.
- `cfg_we`  in  1: write the unit time.
- `cfg_dit`  in  PULSE_CNT_W: new unit time.
- `dit_time`, `dah_time`, `word_time`, `tol_time`  out  PULSE_CNT_W each: capture thresholds.
- `cap_start`  out  1: capture start.
- `cap_len`  in  MORSE_LEN_W; `cap_dits_dahs`  in  MAX_MORSE_LEN; `cap_error`, `cap_word_end`, `cap_ceo`  in  1: capture results.
- `sym_valid`  out  1; `sym_ready`  in  1: output handshake.
- `sym_len`  out  MORSE_LEN_W; `sym_dits_dahs`  out  MAX_MORSE_LEN; `sym_error`, `sym_has_char`, `sym_space`  out  1: FIFO head record.
- `overflow`  out  1: sticky, set when a symbol is dropped.
- `busy`  out  1: state ≠ IDLE.

## Operation
Reset values:
- All outputs are 0, except that the timing outputs reflect DEFAULT_DIT.
- The FIFO is empty and the state is IDLE.

Timing derivation:
- Recomputed from the dit register: dah = 3·dit, word = 7·dit, tol = dit >> TOL_SHIFT.
- Each product saturates to all-ones if it exceeds PULSE_CNT_W.
- cfg_we is accepted only in IDLE. A cfg_dit of 0 is stored as 1. cfg_we in any other state is ignored.

FSM (state advances only when ce=1; enable=0 forces IDLE from any state):
- IDLE: when enable=1, go to WAIT_LOW.
- WAIT_LOW: when signal=0, go to START.
- START: cap_start=1 for exactly this one ce-qualified cycle; go to RUN.
- RUN, on cap_ceo with cap_word_end=0 (character event):
  - Push {has_char=1, space=0, len, dits_dahs, error}, but only if cap_len≠0.
  - Set char_pushed.
- RUN, on cap_ceo with cap_word_end=1 (word event):
  - Push one record: space = ~cap_error, has_char = ~char_pushed & (cap_len≠0), plus len/dits_dahs/error.
  - Go to WAIT_LOW if cap_error=1, otherwise to START.
- char_pushed is cleared on a sampled rising edge of signal (ce=1) and in START.

FIFO:
- A push happens only on ce cycles. A pop happens on any clk where sym_valid & sym_ready, independent of ce.
- Full FIFO with a push and no pop: the record is dropped and overflow is set.
- Full FIFO with a push and a pop in the same cycle: the push is accepted and no overflow occurs.
- Empty FIFO: sym_* fields hold their last value and sym_valid=0.
- overflow is cleared by cfg_we (accepted) or in IDLE.
- Leaving to IDLE flushes the FIFO.

## Timing
- A cap_ceo cycle leads to sym_valid=1 on the next clk edge if the FIFO was empty, so latency is 1.
- Timing outputs update on the clk after an accepted cfg_we.
- cap_start is registered. It is high for the whole START cycle, and during that cycle ce=1 is required for the FSM to advance.
- sym_* must stay stable while sym_valid=1 and sym_ready=0.
- Reset is asynchronous and may assert mid-RUN: all state clears immediately, and cap_start drops in the same cycle.

## Structure
- defines.vh: the width macros listed above, plus SYM_REC_W = MORSE_LEN_W + MAX_MORSE_LEN + 3, plus the FSM state encodings.
- Sub-module morse_sym_fifo: parameterised width/depth synchronous FIFO with async active-low reset, separate push/pop, full/empty flags, same-cycle push+pop when full.
- The top module holds the FSM, the timing arithmetic (shift-and-add, saturation) and the record packing.

## Test plan
- Reset, then cfg_we with cfg_dit=10: outputs dit=10, dah=30, word=70, tol=2. Then cfg_dit=0: dit=1, dah=3, word=7, tol=0.
- PULSE_CNT_W=8, cfg_dit=40: dah=120, word=255 (saturated).
- enable=1 with signal low: exactly one cap_start pulse. A character event with len=3 and dits_dahs=3'b010 gives one record with has_char=1, space=0, on the next cycle.
- Word event after a character event gives a record with space=1, has_char=0, followed by a new cap_start one ce later. A word event with no prior character event and len=2 gives has_char=1, space=1.
- Abort (cap_error=1, cap_word_end=1, signal held high): record with space=0, error=1. The FSM waits in WAIT_LOW, and cap_start fires only after signal falls.
- FIFO_DEPTH=4 with sym_ready=0 and 5 events: 4 records are held and overflow=1. Then a push+pop in the same cycle while full: no loss, and the count stays 4.
